// File: rtl/oc8051_trace_buffer.sv
// oc8051_trace_buffer: timestamped circular trace of PC, write and read events with a PC-match or
// forced trigger, post-trigger fill and an oldest-first valid/ready dump port.
module oc8051_trace_buffer #(
  parameter int unsigned AW      = 8,
  parameter int unsigned TS_W    = 16,
  parameter int unsigned PC_W    = 16,
  parameter int unsigned ADDR_W  = 8,
  localparam int unsigned ENTRY_W = 3 + TS_W + PC_W + 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic               stop,
  input  logic               trig_pc_en,
  input  logic [PC_W-1:0]    trig_pc,
  input  logic [AW-1:0]      post_cnt,
  input  logic [4:0]         ev_mask,
  input  logic [PC_W-1:0]    pc,
  input  logic               wr,
  input  logic [ADDR_W-1:0]  wr_addr,
  input  logic [7:0]         wr_dat,
  input  logic               wr_bit,
  input  logic               bit_in,
  input  logic               rd,
  input  logic [ADDR_W-1:0]  rd_addr,
  input  logic [7:0]         rd_dat,
  input  logic               rd_bit,
  input  logic               bit_dat,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [ENTRY_W-1:0] out_entry,
  output logic               out_last,
  output logic [1:0]         state,
  output logic [7:0]         drop_cnt,
  output logic [AW:0]        level
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW:0] LevelMax = {1'b1, {AW{1'b0}}};

  typedef enum logic [1:0] {StIdle = 2'd0, StArmed = 2'd1, StPost = 2'd2, StDone = 2'd3} state_e;
  typedef enum logic [1:0] {DmStart, DmLoad, DmOut} dump_e;

  state_e state_q, state_d;
  dump_e  dump_q, dump_d;

  logic [TS_W-1:0]    ts_q;
  logic [PC_W-1:0]    last_pc_q;
  logic               wr_v_q, wr_v_d, rd_v_q, rd_v_d, pc_v_q, pc_v_d;
  logic [ENTRY_W-1:0] wr_e_q, wr_e_d, rd_e_q, rd_e_d, pc_e_q, pc_e_d;
  logic               pc_trig_q, pc_trig_d;
  logic [AW-1:0]      wp_q, wp_d, rp_q, rp_d, remain_q, remain_d;
  logic               pend_q, pend_d;
  logic [AW:0]        level_q, level_d, sent_q, sent_d;
  logic [7:0]         drop_q, drop_d;
  logic               out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [ENTRY_W-1:0] out_entry_q, out_entry_d;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ENTRY_W-1:0] mem_rd_q;
  logic               ram_re;
  logic [AW-1:0]      ram_raddr;

  logic               capturing, commit_ok, commit;
  logic               wr_ev, rd_ev, pc_ev, wr_acc, rd_acc, pc_acc;
  logic               wr_drop, rd_drop, pc_drop, pc_trig_hit;
  logic               wr_drain, rd_drain, pc_drain;
  logic [ENTRY_W-1:0] wr_new, rd_new, pc_new, commit_e;
  logic [1:0]         n_drop;
  logic [8:0]         drop_sum;

  assign capturing = (state_q == StArmed || state_q == StPost) && !arm;
  assign pc_ev = capturing && ev_mask[0] && (pc != last_pc_q);
  assign wr_ev = capturing && wr && (wr_bit ? ev_mask[2] : ev_mask[1]);
  assign rd_ev = capturing && rd && (rd_bit ? ev_mask[4] : ev_mask[3]);

  assign wr_new = {(wr_bit ? 3'd3 : 3'd2), ts_q, PC_W'(wr_addr),
                   (wr_bit ? {7'b0, bit_in} : wr_dat)};
  assign rd_new = {(rd_bit ? 3'd5 : 3'd4), ts_q, PC_W'(rd_addr),
                   (rd_bit ? {7'b0, bit_dat} : rd_dat)};
  assign pc_new = {3'd1, ts_q, pc, 8'h00};

  // Once the post-trigger budget is spent, nothing more may reach the RAM.
  assign commit_ok = capturing && (state_q == StArmed || pend_q || remain_q != '0);
  assign wr_drain  = commit_ok && wr_v_q;
  assign rd_drain  = commit_ok && !wr_v_q && rd_v_q;
  assign pc_drain  = commit_ok && !wr_v_q && !rd_v_q && pc_v_q;
  assign commit    = wr_drain || rd_drain || pc_drain;
  assign commit_e  = wr_drain ? wr_e_q : (rd_drain ? rd_e_q : pc_e_q);

  assign wr_acc  = wr_ev && (!wr_v_q || wr_drain);
  assign rd_acc  = rd_ev && (!rd_v_q || rd_drain);
  assign pc_acc  = pc_ev && (!pc_v_q || pc_drain);
  assign wr_drop = wr_ev && !wr_acc;
  assign rd_drop = rd_ev && !rd_acc;
  assign pc_drop = pc_ev && !pc_acc;
  assign pc_trig_hit = (state_q == StArmed) && trig_pc_en && pc_acc && (pc == trig_pc);

  assign n_drop   = {1'b0, wr_drop} + {1'b0, rd_drop} + {1'b0, pc_drop};
  assign drop_sum = {1'b0, drop_q} + {7'b0, n_drop};

  always_comb begin
    state_d     = state_q;
    dump_d      = dump_q;
    wr_v_d      = wr_v_q & ~wr_drain;
    wr_e_d      = wr_acc ? wr_new : wr_e_q;
    rd_v_d      = rd_v_q & ~rd_drain;
    rd_e_d      = rd_acc ? rd_new : rd_e_q;
    pc_v_d      = pc_v_q & ~pc_drain;
    pc_e_d      = pc_acc ? pc_new : pc_e_q;
    pc_trig_d   = pc_acc ? pc_trig_hit : (pc_trig_q & ~pc_drain);
    wp_d        = commit ? wp_q + AW'(1) : wp_q;
    level_d     = (commit && level_q != LevelMax) ? level_q + (AW+1)'(1) : level_q;
    drop_d      = drop_sum[8] ? 8'hff : drop_sum[7:0];
    remain_d    = remain_q;
    pend_d      = pend_q;
    rp_d        = rp_q;
    sent_d      = sent_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_entry_d = out_entry_q;
    ram_re      = 1'b0;
    ram_raddr   = rp_q;
    if (wr_acc) wr_v_d = 1'b1;
    if (rd_acc) rd_v_d = 1'b1;
    if (pc_acc) pc_v_d = 1'b1;

    unique case (state_q)
      StIdle: ;
      StArmed: begin
        if (pc_trig_hit) begin
          state_d  = StPost;
          remain_d = post_cnt;
          pend_d   = 1'b1;
        end else if (stop) begin
          state_d  = StPost;
          remain_d = post_cnt;
          pend_d   = 1'b0;
        end
      end
      StPost: begin
        // The trigger entry itself does not consume post-trigger budget.
        if (commit) begin
          if (pc_drain && pc_trig_q) begin
            pend_d = 1'b0;
            if (remain_q == '0) state_d = StDone;
          end else if (!pend_q) begin
            remain_d = remain_q - AW'(1);
            if (remain_q == AW'(1)) state_d = StDone;
          end
        end else if (!pend_q && remain_q == '0) begin
          state_d = StDone;
        end
      end
      StDone: begin
        unique case (dump_q)
          DmStart: begin
            if (level_q == '0) begin
              state_d = StIdle;
            end else begin
              ram_re    = 1'b1;
              ram_raddr = wp_q - level_q[AW-1:0];
              rp_d      = ram_raddr + AW'(1);
              sent_d    = '0;
              dump_d    = DmLoad;
            end
          end
          DmLoad: begin
            out_valid_d = 1'b1;
            out_entry_d = mem_rd_q;
            out_last_d  = (sent_q + (AW+1)'(1)) == level_q;
            dump_d      = DmOut;
          end
          DmOut: begin
            if (out_ready) begin
              sent_d      = sent_q + (AW+1)'(1);
              out_valid_d = 1'b0;
              if (out_last_q) begin
                state_d     = StIdle;
                dump_d      = DmStart;
                out_last_d  = 1'b0;
                out_entry_d = '0;
              end else begin
                ram_re    = 1'b1;
                ram_raddr = rp_q;
                rp_d      = rp_q + AW'(1);
                dump_d    = DmLoad;
              end
            end
          end
          default: dump_d = DmStart;
        endcase
      end
      default: state_d = StIdle;
    endcase

    // Leftover held events are discarded on freeze without counting as drops.
    if (state_d == StDone || state_d == StIdle) begin
      wr_v_d    = 1'b0;
      rd_v_d    = 1'b0;
      pc_v_d    = 1'b0;
      pc_trig_d = 1'b0;
    end

    if (arm) begin
      state_d     = StArmed;
      dump_d      = DmStart;
      wp_d        = '0;
      level_d     = '0;
      drop_d      = '0;
      wr_v_d      = 1'b0;
      rd_v_d      = 1'b0;
      pc_v_d      = 1'b0;
      pc_trig_d   = 1'b0;
      pend_d      = 1'b0;
      remain_d    = '0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      dump_q      <= DmStart;
      ts_q        <= '0;
      last_pc_q   <= '1;
      wr_v_q      <= 1'b0;
      rd_v_q      <= 1'b0;
      pc_v_q      <= 1'b0;
      wr_e_q      <= '0;
      rd_e_q      <= '0;
      pc_e_q      <= '0;
      pc_trig_q   <= 1'b0;
      wp_q        <= '0;
      rp_q        <= '0;
      remain_q    <= '0;
      pend_q      <= 1'b0;
      level_q     <= '0;
      sent_q      <= '0;
      drop_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_entry_q <= '0;
    end else begin
      state_q     <= state_d;
      dump_q      <= dump_d;
      ts_q        <= ts_q + TS_W'(1);
      last_pc_q   <= pc;
      wr_v_q      <= wr_v_d;
      rd_v_q      <= rd_v_d;
      pc_v_q      <= pc_v_d;
      wr_e_q      <= wr_e_d;
      rd_e_q      <= rd_e_d;
      pc_e_q      <= pc_e_d;
      pc_trig_q   <= pc_trig_d;
      wp_q        <= wp_d;
      rp_q        <= rp_d;
      remain_q    <= remain_d;
      pend_q      <= pend_d;
      level_q     <= level_d;
      sent_q      <= sent_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_entry_q <= out_entry_d;
    end
  end

  always_ff @(posedge clk) begin
    if (commit) mem[wp_q] <= commit_e;
    if (ram_re) mem_rd_q <= mem[ram_raddr];
  end

  assign out_valid = out_valid_q;
  assign out_entry = out_entry_q;
  assign out_last  = out_last_q;
  assign state     = state_q;
  assign drop_cnt  = drop_q;
  assign level     = level_q;

endmodule

// File: tb/tb_oc8051_trace_buffer.sv
// Directed bench for oc8051_trace_buffer with hand-computed expected records (AW=4, DEPTH=16).
module tb_oc8051_trace_buffer;

  localparam int unsigned AW      = 4;
  localparam int unsigned TS_W    = 16;
  localparam int unsigned PC_W    = 16;
  localparam int unsigned ENTRY_W = 3 + TS_W + PC_W + 8;

  logic               clk, rst_n, arm, stop, trig_pc_en;
  logic [15:0]        trig_pc, pc;
  logic [AW-1:0]      post_cnt;
  logic [4:0]         ev_mask;
  logic               wr, wr_bit, bit_in, rd, rd_bit, bit_dat;
  logic [7:0]         wr_addr, wr_dat, rd_addr, rd_dat;
  logic               out_valid, out_ready, out_last;
  logic [ENTRY_W-1:0] out_entry;
  logic [1:0]         state;
  logic [7:0]         drop_cnt;
  logic [AW:0]        level;

  int checks = 0;
  int failures = 0;
  logic [ENTRY_W-1:0] got_e [$];
  bit                 got_l [$];

  int t2_type [10] = '{2, 4, 1, 2, 2, 2, 4, 1, 3, 5};
  int t2_addr [10] = '{'h81, 'h30, 'h100, 'h81, 'h81, 'h81, 'h30, 'h200, 'h20, 'h21};
  int t2_data [10] = '{'h55, 'hAA, 0, 'h55, 'h55, 'h55, 'hAA, 0, 1, 1};

  oc8051_trace_buffer #(.AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .arm        (arm),
    .stop       (stop),
    .trig_pc_en (trig_pc_en),
    .trig_pc    (trig_pc),
    .post_cnt   (post_cnt),
    .ev_mask    (ev_mask),
    .pc         (pc),
    .wr         (wr),
    .wr_addr    (wr_addr),
    .wr_dat     (wr_dat),
    .wr_bit     (wr_bit),
    .bit_in     (bit_in),
    .rd         (rd),
    .rd_addr    (rd_addr),
    .rd_dat     (rd_dat),
    .rd_bit     (rd_bit),
    .bit_dat    (bit_dat),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_entry  (out_entry),
    .out_last   (out_last),
    .state      (state),
    .drop_cnt   (drop_cnt),
    .level      (level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int e_type(input logic [ENTRY_W-1:0] e);
    return int'(e[ENTRY_W-1 -: 3]);
  endfunction
  function automatic int e_ts(input logic [ENTRY_W-1:0] e);
    return int'(e[TS_W+PC_W+7 -: TS_W]);
  endfunction
  function automatic int e_addr(input logic [ENTRY_W-1:0] e);
    return int'(e[PC_W+7 -: PC_W]);
  endfunction
  function automatic int e_data(input logic [ENTRY_W-1:0] e);
    return int'(e[7:0]);
  endfunction

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_arm();
    arm = 1'b1;
    step();
    arm = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    step();
    stop = 1'b0;
  endtask

  // Records each beat at the negedge before the posedge that accepts it.
  task automatic dump_collect(input bit toggle, input int max_beats);
    int cyc = 0;
    got_e.delete();
    got_l.delete();
    out_ready = 1'b0;
    while (got_e.size() < max_beats && cyc < 400) begin
      @(negedge clk);
      cyc++;
      out_ready = toggle ? ~out_ready : 1'b1;
      if (out_valid && out_ready) begin
        got_e.push_back(out_entry);
        got_l.push_back(out_last);
        if (out_last) break;
      end
    end
  endtask

  task automatic check_pc_dump(input string tag, input int n, input int base);
    check({tag, "_beats"}, got_e.size(), n);
    for (int k = 0; k < got_e.size(); k++) begin
      check({tag, "_type"}, e_type(got_e[k]), 1);
      check({tag, "_pc"}, e_addr(got_e[k]), base + k);
      check({tag, "_last"}, got_l[k], k == n - 1);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; arm = 1'b0; stop = 1'b0; trig_pc_en = 1'b0; trig_pc = '0; post_cnt = '0;
    ev_mask = 5'h1f; pc = 16'hFFFF; wr = 1'b0; wr_addr = '0; wr_dat = '0; wr_bit = 1'b0;
    bit_in = 1'b0; rd = 1'b0; rd_addr = '0; rd_dat = '0; rd_bit = 1'b0; bit_dat = 1'b0;
    out_ready = 1'b0;
    step(2);
    check("rst_state", state, 0);
    check("rst_valid", out_valid, 0);
    check("rst_last", out_last, 0);
    check("rst_entry", out_entry, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_level", level, 0);
    rst_n = 1'b1;
    step(2);

    // 1: ten PC values, two cycles each, forced stop.
    do_arm();
    check("t1_armed", state, 1);
    for (int i = 0; i < 10; i++) begin
      pc = 16'(i);
      step(2);
    end
    step(3);
    check("t1_level", level, 10);
    do_stop();
    dump_collect(1'b0, 64);
    check_pc_dump("t1", 10, 0);
    for (int k = 1; k < got_e.size(); k++)
      check("t1_ts_delta", (e_ts(got_e[k]) - e_ts(got_e[k-1])) & 'hFFFF, 2);
    step();
    check("t1_idle", state, 0);
    check("t1_valid_off", out_valid, 0);

    // 2: simultaneous WR/RD/PC, back-to-back triples, bit ops, drop saturation.
    do_arm();
    wr = 1'b1; wr_addr = 8'h81; wr_dat = 8'h55; rd = 1'b1; rd_addr = 8'h30; rd_dat = 8'hAA;
    pc = 16'h0100;
    step();
    wr = 1'b0; rd = 1'b0;
    step(4);
    check("t2_level_a", level, 3);
    check("t2_drop_a", drop_cnt, 0);
    wr = 1'b1; rd = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pc = 16'h0200 + 16'(i);
      step();
    end
    wr = 1'b0; rd = 1'b0;
    step(6);
    check("t2_drop_b", drop_cnt, 4);
    check("t2_level_b", level, 8);
    wr = 1'b1; wr_bit = 1'b1; bit_in = 1'b1; wr_addr = 8'h20;
    rd = 1'b1; rd_bit = 1'b1; bit_dat = 1'b1; rd_addr = 8'h21;
    step();
    wr = 1'b0; rd = 1'b0; wr_bit = 1'b0; rd_bit = 1'b0;
    step(3);
    check("t2_level_c", level, 10);
    do_stop();
    dump_collect(1'b0, 64);
    check("t2_beats", got_e.size(), 10);
    for (int k = 0; k < got_e.size() && k < 10; k++) begin
      check("t2_type", e_type(got_e[k]), t2_type[k]);
      check("t2_addr", e_addr(got_e[k]), t2_addr[k]);
      check("t2_data", e_data(got_e[k]), t2_data[k]);
    end
    if (got_e.size() >= 3) begin
      check("t2_ts_rd", e_ts(got_e[1]), e_ts(got_e[0]));
      check("t2_ts_pc", e_ts(got_e[2]), e_ts(got_e[0]));
    end
    step();
    wr_addr = 8'h81; rd_addr = 8'h30;
    do_arm();
    wr = 1'b1; rd = 1'b1;
    for (int i = 0; i < 140; i++) begin
      pc = 16'h0300 + 16'(i);
      step();
    end
    wr = 1'b0; rd = 1'b0;
    step(3);
    check("t2_drop_sat", drop_cnt, 255);
    check("t2_level_sat", level, 16);

    // 3: 40 PC events into a 16-deep buffer keep only the newest 16.
    do_arm();
    check("t3_drop_clr", drop_cnt, 0);
    for (int i = 0; i < 40; i++) begin
      pc = 16'h1000 + 16'(i);
      step();
    end
    step(3);
    check("t3_level", level, 16);
    check("t3_drop", drop_cnt, 0);
    do_stop();
    dump_collect(1'b0, 64);
    check_pc_dump("t3", 16, 'h1018);
    step();

    // 4: PC-match trigger with four post-trigger entries; dump starts 2 cycles into DONE.
    trig_pc_en = 1'b1; trig_pc = 16'h0123; post_cnt = 4'd4;
    do_arm();
    for (int i = 0; i < 11; i++) begin
      pc = 16'h0120 + 16'(i);
      step();
      if (i == 3) check("t4_post", state, 2);
      if (i == 8) check("t4_done", state, 3);
      if (i == 8) check("t4_valid_d0", out_valid, 0);
      if (i == 9) check("t4_valid_d1", out_valid, 0);
      if (i == 10) check("t4_valid_d2", out_valid, 1);
    end
    trig_pc_en = 1'b0; post_cnt = '0;
    dump_collect(1'b0, 64);
    check_pc_dump("t4", 8, 'h0120);
    step();

    // 5: toggling ready, then reset in the middle of a dump.
    do_arm();
    for (int i = 0; i < 6; i++) begin
      pc = 16'h0500 + 16'(i);
      step();
    end
    step(3);
    do_stop();
    dump_collect(1'b1, 64);
    check_pc_dump("t5", 6, 'h0500);
    step();
    out_ready = 1'b0;
    do_arm();
    for (int i = 0; i < 6; i++) begin
      pc = 16'h0500 + 16'(i);
      step();
    end
    step(3);
    do_stop();
    dump_collect(1'b0, 3);
    check("t5_mid_beats", got_e.size(), 3);
    rst_n = 1'b0;
    #1;
    check("t5_rst_state", state, 0);
    check("t5_rst_valid", out_valid, 0);
    check("t5_rst_last", out_last, 0);
    check("t5_rst_entry", out_entry, 0);
    check("t5_rst_level", level, 0);
    step();
    rst_n = 1'b1;
    out_ready = 1'b0;
    step(2);

    // 6: PC-only mask under mixed traffic; arm during POST restarts capture.
    ev_mask = 5'b00001;
    do_arm();
    wr = 1'b1; rd = 1'b1;
    for (int i = 0; i < 5; i++) begin
      pc = 16'h0600 + 16'(i);
      wr_bit = i[0];
      rd_bit = i[1];
      step();
    end
    wr = 1'b0; rd = 1'b0; wr_bit = 1'b0; rd_bit = 1'b0;
    step(3);
    check("t6_drop", drop_cnt, 0);
    do_stop();
    dump_collect(1'b0, 64);
    check_pc_dump("t6", 5, 'h0600);
    step();
    trig_pc_en = 1'b1; trig_pc = 16'h0702; post_cnt = 4'd10;
    do_arm();
    for (int i = 0; i < 5; i++) begin
      pc = 16'h0700 + 16'(i);
      step();
    end
    step(3);
    check("t6_post", state, 2);
    check("t6_level_post", level, 5);
    do_arm();
    check("t6_rearm_state", state, 1);
    check("t6_rearm_level", level, 0);
    check("t6_rearm_drop", drop_cnt, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
